// File: rtl/pid_channel_scheduler.sv
// ============================================================================
// Module      : pid_channel_scheduler
// Description : Shares one PID engine across NCH control loops. It arbitrates
//               requests, holds the per-channel error and integral state, and
//               drives a clamped 8-bit output for each channel.
//               Option macro: PID_SCHED_FIXED_PRIO_EN selects fixed priority
//               (lowest index wins) in place of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_channel_scheduler #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*8-1:0]     setpoint,
    input  logic [NCH*8-1:0]     feedback,
    output logic [NCH-1:0]       ack,
    output logic [NCH*8-1:0]     ctrl_out,
    output logic                 busy,
    output logic [CHW-1:0]       cur_ch,
    output logic                 eng_start,
    output logic [15:0]          eng_error,
    output logic [15:0]          eng_prev_error,
    output logic [15:0]          eng_integral,
    input  logic                 eng_done,
    input  logic [15:0]          eng_result,
    input  logic [15:0]          eng_integral_nxt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [NCH-1:0][7:0]    r_ctrl;
    logic [15:0]            r_prev  [NCH];
    logic [15:0]            r_integ [NCH];
    logic [NCH-1:0]         r_ack;
    logic                   r_busy;
    logic [CHW-1:0]         r_ch;
    logic                   r_start;
    logic [15:0]            r_err;

    logic [NCH-1:0][7:0]    w_sp;
    logic [NCH-1:0][7:0]    w_fb;
    logic [15:0]            w_err;
    logic [7:0]             w_clamp;
    logic [CHW-1:0]         w_win;
    logic                   w_engaged;

    assign w_sp      = setpoint;
    assign w_fb      = feedback;
    assign w_err     = {8'b0, w_sp[r_ch]} - {8'b0, w_fb[r_ch]};
    assign w_engaged = (r_state == S_LOAD) || (r_state == S_WAIT);

    // Negative results floor at 0, anything above 255 saturates.
    assign w_clamp = eng_result[15]     ? 8'h00 :
                     (|eng_result[14:8]) ? 8'hFF : eng_result[7:0];

    assign ack            = r_ack;
    assign ctrl_out       = r_ctrl;
    assign busy           = r_busy;
    assign cur_ch         = r_ch;
    assign eng_start      = r_start;
    assign eng_error      = (r_state == S_LOAD) ? w_err : r_err;
    assign eng_prev_error = w_engaged ? r_prev[r_ch]  : 16'h0000;
    assign eng_integral   = w_engaged ? r_integ[r_ch] : 16'h0000;

`ifdef PID_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) w_win = CHW'(i);
        end
    end
`else
    logic [CHW-1:0] r_ptr;
    logic [CHW-1:0] w_next;

    assign w_next = (int'(r_ch) == NCH - 1) ? '0 : r_ch + 1'b1;

    // Scan downward so the set bit closest to the pointer is assigned last.
    always_comb begin
        w_win = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[(int'(r_ptr) + i) % NCH]) w_win = CHW'((int'(r_ptr) + i) % NCH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_ptr <= '0;
        else if (r_state == S_DONE)  r_ptr <= w_next;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_ch    <= '0;
            r_start <= 1'b0;
            r_err   <= 16'h0000;
            for (int i = 0; i < NCH; i++) begin
                r_prev[i]  <= 16'h0000;
                r_integ[i] <= 16'h0000;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_ch    <= w_win;
                        r_busy  <= 1'b1;
                        r_start <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_err   <= w_err;
                    r_start <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        r_prev[r_ch]  <= r_err;
                        r_integ[r_ch] <= eng_integral_nxt;
                        r_ctrl[r_ch]  <= w_clamp;
                        r_ack[r_ch]   <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                default: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pid_channel_scheduler.sv
// ============================================================================
// Module      : tb_pid_channel_scheduler
// Description : Directed self-checking bench for pid_channel_scheduler with a
//               hand-driven engine stub. Honours PID_SCHED_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pid_channel_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] setpoint;
    logic [31:0] feedback;
    logic [3:0]  ack;
    logic [31:0] ctrl_out;
    logic        busy;
    logic [1:0]  cur_ch;
    logic        eng_start;
    logic [15:0] eng_error;
    logic [15:0] eng_prev_error;
    logic [15:0] eng_integral;
    logic        eng_done;
    logic [15:0] eng_result;
    logic [15:0] eng_integral_nxt;

    logic [3:0][7:0] m_ctrl;
    int n_cmp = 0;
    int n_bad = 0;

    pid_channel_scheduler #(.NCH(4), .CHW(2)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .setpoint         (setpoint),
        .feedback         (feedback),
        .ack              (ack),
        .ctrl_out         (ctrl_out),
        .busy             (busy),
        .cur_ch           (cur_ch),
        .eng_start        (eng_start),
        .eng_error        (eng_error),
        .eng_prev_error   (eng_prev_error),
        .eng_integral     (eng_integral),
        .eng_done         (eng_done),
        .eng_result       (eng_result),
        .eng_integral_nxt (eng_integral_nxt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [7:0] sp, input logic [7:0] fb);
        setpoint[ch*8 +: 8] = sp;
        feedback[ch*8 +: 8] = fb;
        req[ch]             = 1'b1;
    endtask

    // One full service: wait for start, check LOAD view, answer, check ack.
    task automatic serve(input int ch, input logic [15:0] exp_err, input logic [15:0] exp_prev,
                         input logic [15:0] exp_int, input logic [15:0] res, input logic [15:0] inxt,
                         input logic [7:0] exp_ctrl, input int extra, input bit keep_req, input bit drop);
        int t = 0;
        while (eng_start !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10) begin
            check_val("start_timeout", 32'd0, 32'd1);
            return;
        end
        check_val("load_cur_ch", 32'(cur_ch), 32'(ch));
        check_val("load_busy",   32'(busy), 32'd1);
        check_val("load_err",    32'(eng_error), 32'(exp_err));
        check_val("load_prev",   32'(eng_prev_error), 32'(exp_prev));
        check_val("load_integ",  32'(eng_integral), 32'(exp_int));
        @(negedge clk);
        check_val("wait_start_low", 32'(eng_start), 32'd0);
        if (drop) req[ch] = 1'b0;
        repeat (extra) @(negedge clk);
        check_val("wait_err_held", 32'(eng_error), 32'(exp_err));
        eng_done         = 1'b1;
        eng_result       = res;
        eng_integral_nxt = inxt;
        @(negedge clk);
        eng_done    = 1'b0;
        m_ctrl[ch]  = exp_ctrl;
        check_val("done_ack", 32'(ack), 32'(4'b0001 << ch));
        check_val("done_ctrl", ctrl_out, m_ctrl);
        if (!keep_req) req[ch] = 1'b0;
        @(negedge clk);
        check_val("idle_ack", 32'(ack), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int  order [5];
        bit  seen  [4];
        int  t;
        logic any_busy;
        logic [15:0] e;

        rst_n = 1'b0; req = '0; setpoint = '0; feedback = '0;
        eng_done = 1'b0; eng_result = '0; eng_integral_nxt = '0;
        m_ctrl = '0;
        repeat (2) @(negedge clk);
        check_val("rst_ack",   32'(ack), 32'd0);
        check_val("rst_ctrl",  ctrl_out, 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_start", 32'(eng_start), 32'd0);
        check_val("rst_err",   32'(eng_error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request on ch2: error 60, result 2*error.
        set_ch(2, 8'd100, 8'd40);
        serve(2, 16'd60, 16'd0, 16'd0, 16'd120, 16'd60, 8'd120, 0, 0, 0);

        // Clamp cases.
        set_ch(0, 8'd200, 8'd50);
        serve(0, 16'd150, 16'd0, 16'd0, 16'd300, 16'd150, 8'd255, 1, 0, 0);
        set_ch(3, 8'd10, 8'd20);
        serve(3, 16'hFFF6, 16'd0, 16'd0, 16'hFFEC, 16'hFFF6, 8'd0, 0, 0, 0);

        // Persistence on ch1: first error 30 (result 255 edge), then 50.
        set_ch(1, 8'd80, 8'd50);
        serve(1, 16'd30, 16'd0, 16'd0, 16'd255, 16'd30, 8'd255, 0, 0, 0);
        set_ch(1, 8'd90, 8'd40);
        serve(1, 16'd50, 16'd30, 16'd30, 16'd100, 16'd80, 8'd100, 2, 0, 0);

        // req dropped during WAIT still completes, no second service.
        set_ch(2, 8'd50, 8'd45);
        serve(2, 16'd5, 16'd60, 16'd60, 16'd10, 16'd65, 8'd10, 2, 0, 1);
        any_busy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_busy = any_busy | busy;
        end
        check_val("drop_no_reservice", 32'(any_busy), 32'd0);

        // Reset in WAIT with eng_done outstanding.
        set_ch(1, 8'd60, 8'd10);
        t = 0;
        while (eng_start !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check_val("mid_start_seen", 32'(eng_start), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        m_ctrl = '0;
        #1;
        check_val("mid_rst_ctrl",   ctrl_out, 32'd0);
        check_val("mid_rst_busy",   32'(busy), 32'd0);
        check_val("mid_rst_cur_ch", 32'(cur_ch), 32'd0);
        check_val("mid_rst_err",    32'(eng_error), 32'd0);
        check_val("mid_rst_prev",   32'(eng_prev_error), 32'd0);
        check_val("mid_rst_integ",  32'(eng_integral), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        eng_done = 1'b1; eng_result = 16'd77; eng_integral_nxt = 16'd5;
        @(negedge clk);
        eng_done = 1'b0;
        check_val("late_done_ack",  32'(ack), 32'd0);
        check_val("late_done_ctrl", ctrl_out, 32'd0);
        @(negedge clk);
        check_val("late_done_busy", 32'(busy), 32'd0);

        // All four requesting: error for channel i is 10*(i+1).
`ifdef PID_SCHED_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        seen = '{0, 0, 0, 0};
        for (int c = 0; c < 4; c++) set_ch(c, 8'(10 * (c + 1)), 8'd0);
        for (int k = 0; k < 5; k++) begin
            e = 16'(10 * (order[k] + 1));
            serve(order[k], e, seen[order[k]] ? e : 16'd0, seen[order[k]] ? e : 16'd0,
                  16'(2 * e), e, 8'(2 * e), 0, 1, 0);
            seen[order[k]] = 1'b1;
        end
        req = '0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pid_channel_scheduler.md
# pid_channel_scheduler

Time-multiplexes one shared PID compute engine across `NCH` independent control loops. Arbitrates channel requests, computes the channel error, and presents the engine with that channel's stored state: previous error and integral. When the engine finishes, the scheduler writes back the state and drives the channel's clamped 8-bit control output. Sits between the top-level I/O and the single PID datapath, so one arithmetic engine serves several loops.

## Interface
Parameters:
- `NCH`, 4, number of channels (2..8)
- `CHW`, 2, channel index width, equal to clog2(`NCH`)

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `req` in NCH: per-channel request level; hold high until `ack` is seen.
- `setpoint` in NCH*8: channel i occupies bits [8i+7:8i], unsigned.
- `feedback` in NCH*8: same packing, unsigned.
- `ack` out NCH: one-cycle completion pulse for the served channel.
- `ctrl_out` out NCH*8: registered per-channel control outputs.
- `busy` out 1: high in every state except IDLE.
- `cur_ch` out CHW: index of the channel being served; valid while `busy` is high.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_error` out 16: signed error of the served channel.
- `eng_prev_error` out 16: signed stored previous error.
- `eng_integral` out 16: signed stored integral.
- `eng_done` in 1: engine completion; never asserted in the same cycle as `eng_start`.
- `eng_result` in 16: signed raw PID sum.
- `eng_integral_nxt` in 16: signed updated integral.

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - If any `req` bit is high, latch the winner into `cur_ch`, then go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `eng_error` = {8'b0, setpoint[ch]} - {8'b0, feedback[ch]}; range -255..+255. Register it into a held copy used through WAIT.
  - Assert `eng_start` for this single cycle, then go to WAIT.
  - `eng_prev_error` and `eng_integral` are driven from the per-channel state registers for the whole LOAD..WAIT interval.
- WAIT:
  - Stay until `eng_done` is high.
  - On the edge where `eng_done` is sampled high: `prev_error[ch]` <= held error, `integral[ch]` <= `eng_integral_nxt`, `ctrl_out[ch]` <= clamp(`eng_result`), set `ack[ch]`, go to DONE.
- DONE:
  - `ack[ch]` is high for this single cycle.
  - Advance the round-robin pointer to (ch+1) mod NCH, then go to IDLE.
- Clamp rule: `eng_result` > 255 gives 255; `eng_result` < 0 gives 0; otherwise `eng_result`[7:0].
- Arbitration: round-robin. Search starts at the pointer and takes the first `req` bit set, with wrap-around. Pointer resets to 0.
- A `req` that drops during LOAD or WAIT does not abort; the service still completes and `ack` still pulses.
- `setpoint`/`feedback` changes after LOAD do not affect the current service.
- A channel whose `req` is still high in the IDLE after DONE is treated as a new request, but round-robin places it last.
- Channels not being served keep `ctrl_out`, `prev_error` and `integral` unchanged.

## Timing
- Reset, asynchronous and effective immediately in any state: FSM goes to IDLE. All of these clear to 0: `ctrl_out`, `ack`, `busy`, `cur_ch`, `eng_start`, `eng_error`, `eng_prev_error`, `eng_integral`, all `prev_error[]`, all `integral[]`, and the pointer.
- Reset during WAIT abandons the engine operation. A late `eng_done` that arrives after reset, while in IDLE, is ignored.
- Sequence for a request in an idle scheduler:
  - Cycle 0: IDLE samples `req`.
  - Cycle 1: LOAD, `eng_start` high.
  - Cycle 2 or later: WAIT.
  - `eng_done` sampled in cycle k gives `ack` and the new `ctrl_out` visible in cycle k+1.
  - Back in IDLE at cycle k+2.
- Minimum turnaround with `eng_done` in cycle 2: 4 cycles per service.
- Requesters drop `req` on the edge after they observe `ack`.

## Configuration
- Macro `PID_SCHED_FIXED_PRIO_EN`.
- Defined: arbitration is fixed priority, lowest index wins. The pointer register is removed and `cur_ch` selection ignores history.
- Undefined (default): round-robin as specified above.

## Test plan
- Single request:
  - Stimulus: ch2 `req`, sp=100, fb=40, stub engine returns done 2 cycles after start with result = 2·error.
  - Required: `eng_error`=60, `ctrl_out[2]`=120, `ack[2]` one cycle, other outputs unchanged.
- Simultaneous requests:
  - Stimulus: `req`=4'b1111 held, re-asserted after each `ack`.
  - Required (round-robin): service order 0,1,2,3,0.
  - Required (`PID_SCHED_FIXED_PRIO_EN`): ch0 served repeatedly.
- Clamp:
  - result=300 gives `ctrl_out`=255.
  - result=-20 (sp=10, fb=20) gives 0.
  - result=255 gives 255.
- State persistence: ch1 served twice, first with error 30, then error 50.
  - Second service: `eng_prev_error`=30.
  - Second service: `eng_integral` equals the first `eng_integral_nxt`.
- Reset mid-WAIT: assert `rst_n` low with `eng_done` still pending.
  - Required: all outputs 0 immediately.
  - Required: a later `eng_done` produces no `ack` and no `ctrl_out` change.
- `req` dropped during WAIT: completion and `ack` still occur; no second service.
